// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter.
//   arb_state_t : sequencer states (idle, memory busy, completion pulse)
//   OWN_IF/OWN_DM : owner encoding for the fetch and data ports
package cpu_defs;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port, memory port and stall lines.
//   slave  : the arbiter's view (requests and memory read data in,
//            completions, memory controls and stalls out)
//   master : the pipeline/memory view (the opposite directions)
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ready;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              stall_IF;
  logic              stall_MEM;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ready, dm_rdata, dm_ready,
           mem_en, mem_we, mem_addr, mem_wdata, stall_IF, stall_MEM
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ready, dm_rdata, dm_ready,
           mem_en, mem_we, mem_addr, mem_wdata, stall_IF, stall_MEM
  );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Combinational two-way picker.
//   req_if, req_dm : pending requests
//   last_owner     : owner of the most recently completed transaction
//   grant          : some request is pending
//   winner         : port to serve; on a tie the port that did not go last
module arb_pick2
  import cpu_defs::*;
(
  input  logic req_if,
  input  logic req_dm,
  input  logic last_owner,
  output logic grant,
  output logic winner
);

  always_comb begin
    grant  = req_if | req_dm;
    winner = OWN_IF;
    if (req_if && req_dm) begin
      winner = ~last_owner;
    end else if (req_dm) begin
      winner = OWN_DM;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and
// data access. Each transaction holds mem_en for LATENCY cycles, then the
// owner gets a one-cycle ready pulse with its read data.
//   clock, reset : rising-edge clock, asynchronous active-low reset
//   bus          : fetch/data request ports, memory port, stall outputs
module mem_port_arbiter
  import cpu_defs::*;
#(
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic               clock,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              owner_q;
  logic              last_owner_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              if_ready_q;
  logic              dm_ready_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;

  logic grant;
  logic winner;
  logic start;
  logic finish;

  arb_pick2 u_pick (
    .req_if     (bus.if_req),
    .req_dm     (bus.dm_req),
    .last_owner (last_owner_q),
    .grant      (grant),
    .winner     (winner)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    finish  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (grant) begin
          start   = 1'b1;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (cnt_q == '0) begin
          finish  = 1'b1;
          state_d = ARB_DONE;
        end
      end
      ARB_DONE: begin
        // Requests are not looked at here: a request still high now is
        // treated as a fresh transaction once back in IDLE.
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q        <= '0;
      owner_q      <= OWN_IF;
      last_owner_q <= OWN_IF;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_ready_q   <= 1'b0;
      dm_ready_q   <= 1'b0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
    end else begin
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
      if (start) begin
        // Memory-side controls are latched here, so requester inputs
        // moving during BUSY cannot disturb the access in flight.
        owner_q  <= winner;
        cnt_q    <= CNT_LOAD;
        mem_en_q <= 1'b1;
        if (winner == OWN_DM) begin
          mem_we_q    <= bus.dm_we;
          mem_addr_q  <= bus.dm_addr;
          mem_wdata_q <= bus.dm_wdata;
        end else begin
          mem_we_q    <= 1'b0;
          mem_addr_q  <= bus.if_addr;
          mem_wdata_q <= '0;
        end
      end else if (finish) begin
        mem_en_q     <= 1'b0;
        mem_we_q     <= 1'b0;
        last_owner_q <= owner_q;
        if (owner_q == OWN_IF) begin
          if_rdata_q <= bus.mem_rdata;
          if_ready_q <= 1'b1;
        end else begin
          if (!mem_we_q) begin
            dm_rdata_q <= bus.mem_rdata;
          end
          dm_ready_q <= 1'b1;
        end
      end else if (state_q == ARB_BUSY) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.dm_ready  = dm_ready_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;

  assign bus.stall_IF  = bus.if_req & ~if_ready_q;
  assign bus.stall_MEM = bus.dm_req & ~dm_ready_q;

endmodule
